// File: rtl/tap_pkg.sv
// tap_pkg: shared types and constants for the TAP controller.
// Holds the 16-state TAP enum, using the standard 1149.1 state codes so
// that TapState matches what debug tooling expects, plus the opcodes the
// controller decodes from the instruction register.
package tap_pkg;

  localparam int INSTR_W = 8;

  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PAU_DR = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PAU_IR = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tap_state_e;

  localparam logic [INSTR_W-1:0] OP_IDCODE      = 8'h01;
  localparam logic [INSTR_W-1:0] OP_BIST_RUN    = 8'h02;
  localparam logic [INSTR_W-1:0] OP_BIST_STATUS = 8'h03;

endpackage

// File: rtl/tap_ctrl_if.sv
// tap_ctrl_if: signal bundle between the TAP controller and the test-access
// path (serial pins, IR and DR interfaces, strobes, selects, debug state).
// Modports:
//   slave  - the controller: takes TMS/TDI and register serial/parallel
//            outputs, drives TDO, strobes, selects, BistStart, TapState.
//   master - the surrounding test logic: the mirror image of slave.
interface tap_ctrl_if #(parameter int INSTR_W = 8);
  logic               TMS;
  logic               TDI;
  logic [INSTR_W-1:0] IR_PO;
  logic               IR_SO;
  logic               IDCODE_SO;
  logic               BIST_SO;
  logic               TDO;
  logic               TDO_EN;
  logic               CaptureIR;
  logic               ShiftIR;
  logic               UpdateIR;
  logic               CaptureDR;
  logic               ShiftDR;
  logic               UpdateDR;
  logic               TapReset;
  logic               SelIdcode;
  logic               SelBistStatus;
  logic               SelBypass;
  logic               BistStart;
  logic [3:0]         TapState;

  modport slave (
    input  TMS, TDI, IR_PO, IR_SO, IDCODE_SO, BIST_SO,
    output TDO, TDO_EN, CaptureIR, ShiftIR, UpdateIR,
           CaptureDR, ShiftDR, UpdateDR, TapReset,
           SelIdcode, SelBistStatus, SelBypass, BistStart, TapState
  );

  modport master (
    output TMS, TDI, IR_PO, IR_SO, IDCODE_SO, BIST_SO,
    input  TDO, TDO_EN, CaptureIR, ShiftIR, UpdateIR,
           CaptureDR, ShiftDR, UpdateDR, TapReset,
           SelIdcode, SelBistStatus, SelBypass, BistStart, TapState
  );
endinterface

// File: rtl/tap_fsm.sv
// tap_fsm: the 16-state TAP state machine (state register + next state).
// Ports:
//   clk   - test clock, rising edge
//   rst   - synchronous active-high reset to TLR
//   tms   - test mode select
//   state - current TAP state
module tap_fsm
  import tap_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tms,
  output tap_state_e state
);

  tap_state_e state_next;

  always_ff @(posedge clk) begin
    if (rst) state <= TLR;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      TLR:    state_next = tms ? TLR    : RTI;
      RTI:    state_next = tms ? SEL_DR : RTI;
      SEL_DR: state_next = tms ? SEL_IR : CAP_DR;
      CAP_DR: state_next = tms ? EX1_DR : SH_DR;
      SH_DR:  state_next = tms ? EX1_DR : SH_DR;
      EX1_DR: state_next = tms ? UPD_DR : PAU_DR;
      PAU_DR: state_next = tms ? EX2_DR : PAU_DR;
      EX2_DR: state_next = tms ? UPD_DR : SH_DR;
      UPD_DR: state_next = tms ? SEL_DR : RTI;
      SEL_IR: state_next = tms ? TLR    : CAP_IR;
      CAP_IR: state_next = tms ? EX1_IR : SH_IR;
      SH_IR:  state_next = tms ? EX1_IR : SH_IR;
      EX1_IR: state_next = tms ? UPD_IR : PAU_IR;
      PAU_IR: state_next = tms ? EX2_IR : PAU_IR;
      EX2_IR: state_next = tms ? UPD_IR : SH_IR;
      UPD_IR: state_next = tms ? SEL_DR : RTI;
      default: state_next = TLR;
    endcase
  end

endmodule

// File: rtl/tap_ctrl.sv
// tap_ctrl: TAP controller for the BIST test-access path.
// Runs the TAP FSM, produces Moore Capture/Shift/Update strobes for IR and
// DRs, decodes the IR into one-hot DR selects, owns the BYPASS bit and the
// TDO mux, and pulses BistStart once when a BIST_RUN instruction or DR
// update completes into Run-Test/Idle.
// Ports:
//   TCLK   - test clock, all state changes on the rising edge
//   TRESET - synchronous active-high reset
//   bus    - tap_ctrl_if.slave bundle (pins, IR/DR links, strobes, selects)
module tap_ctrl
  import tap_pkg::*;
#(
  parameter int                 INSTR_W        = tap_pkg::INSTR_W,
  parameter logic [INSTR_W-1:0] OP_IDCODE      = tap_pkg::OP_IDCODE,
  parameter logic [INSTR_W-1:0] OP_BIST_RUN    = tap_pkg::OP_BIST_RUN,
  parameter logic [INSTR_W-1:0] OP_BIST_STATUS = tap_pkg::OP_BIST_STATUS
) (
  input logic       TCLK,
  input logic       TRESET,
  tap_ctrl_if.slave bus
);

  tap_state_e state;
  tap_state_e prev_state;
  logic       bypass_q;
  logic       tap_reset;
  logic       sel_idcode;
  logic       sel_bist;
  logic       sel_bypass;
  logic       tdo;

  tap_fsm u_fsm (
    .clk   (TCLK),
    .rst   (TRESET),
    .tms   (bus.TMS),
    .state (state)
  );

  // Previous state lets BistStart be a function of the arc into RTI,
  // so idling in RTI or arriving from TLR never pulses.
  always_ff @(posedge TCLK) begin
    if (TRESET) prev_state <= TLR;
    else        prev_state <= state;
  end

  assign tap_reset = (state == TLR);

  // TLR overrides the decode so the path is always BYPASS while in reset.
  assign sel_idcode = !tap_reset && (bus.IR_PO == OP_IDCODE);
  assign sel_bist   = !tap_reset && (bus.IR_PO == OP_BIST_STATUS);
  assign sel_bypass = !sel_idcode && !sel_bist;

  always_ff @(posedge TCLK) begin
    if (TRESET) begin
      bypass_q <= 1'b0;
    end else if (sel_bypass) begin
      if (state == CAP_DR)     bypass_q <= 1'b0;
      else if (state == SH_DR) bypass_q <= bus.TDI;
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (state == SH_IR) begin
      tdo = bus.IR_SO;
    end else if (state == SH_DR) begin
      if (sel_idcode)    tdo = bus.IDCODE_SO;
      else if (sel_bist) tdo = bus.BIST_SO;
      else               tdo = bypass_q;
    end
  end

  assign bus.TDO           = tdo;
  assign bus.TDO_EN        = (state == SH_IR) || (state == SH_DR);
  assign bus.CaptureIR     = (state == CAP_IR);
  assign bus.ShiftIR       = (state == SH_IR);
  assign bus.UpdateIR      = (state == UPD_IR);
  assign bus.CaptureDR     = (state == CAP_DR);
  assign bus.ShiftDR       = (state == SH_DR);
  assign bus.UpdateDR      = (state == UPD_DR);
  assign bus.TapReset      = tap_reset;
  assign bus.SelIdcode     = sel_idcode;
  assign bus.SelBistStatus = sel_bist;
  assign bus.SelBypass     = sel_bypass;
  assign bus.BistStart     = (state == RTI)
                           && ((prev_state == UPD_IR) || (prev_state == UPD_DR))
                           && (bus.IR_PO == OP_BIST_RUN);
  assign bus.TapState      = state;

endmodule

// File: doc/tap_ctrl.md
Name: tap_ctrl

Overview:
- IEEE 1149.1-style TAP controller that sequences the 8-bit instruction register and the data registers of the BIST test-access path.
- Runs the 16-state TAP FSM from TMS and generates the Capture/Shift/Update strobes for the IR and the DRs.
- Decodes the IR parallel output into DR selects and owns the 1-bit BYPASS register.
- Owns the TDO mux and issues a single-cycle BIST start pulse.

Parameters:
- INSTR_W, 8, IR width; must match the IR parallel output.
- OP_IDCODE, 8'h01, opcode that selects the IDCODE DR.
- OP_BIST_RUN, 8'h02, opcode that arms BistStart and selects BYPASS.
- OP_BIST_STATUS, 8'h03, opcode that selects the BIST status DR.

Ports:
- TCLK  in  1  test clock; all state changes on rising edge.
- TRESET  in  1  synchronous active-high reset.
- TMS  in  1  test mode select.
- TDI  in  1  serial data in; feeds the BYPASS register.
- IR_PO  in  INSTR_W  IR parallel (updated) instruction.
- IR_SO  in  1  IR serial out (IR bit 0).
- IDCODE_SO  in  1  IDCODE DR serial out.
- BIST_SO  in  1  BIST status DR serial out.
- TDO  out  1  serial data out.
- TDO_EN  out  1  high while shifting.
- CaptureIR, ShiftIR, UpdateIR  out  1 each  IR strobes.
- CaptureDR, ShiftDR, UpdateDR  out  1 each  DR strobes, common to all DRs.
- TapReset  out  1  high in TEST_LOGIC_RESET.
- SelIdcode, SelBistStatus, SelBypass  out  1 each  one-hot DR select.
- BistStart  out  1  one-cycle start pulse.
- TapState  out  4  current state, for debug.

Behaviour:
- Reset:
  - TRESET=1 at a rising TCLK edge forces TEST_LOGIC_RESET (TLR) and clears the bypass register and the previous-state register.
  - Outputs in reset: TapReset=1; all strobes 0; BistStart=0; TDO_EN=0; TDO=0.
  - TRESET mid-shift aborts the shift immediately; UpdateIR/UpdateDR are not generated.
- FSM transitions (TMS sampled on rising edge; values given as TMS=0 / TMS=1):
  - TLR -> RTI / TLR
  - RTI -> RTI / SEL_DR
  - SEL_DR -> CAP_DR / SEL_IR
  - CAP_DR -> SH_DR / EX1_DR
  - SH_DR -> SH_DR / EX1_DR
  - EX1_DR -> PAU_DR / UPD_DR
  - PAU_DR -> PAU_DR / EX2_DR
  - EX2_DR -> SH_DR / UPD_DR
  - UPD_DR -> RTI / SEL_DR
  - IR column is identical: SEL_IR -> CAP_IR / TLR; then CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR with the same arcs as the DR column.
  - From any state, five consecutive TMS=1 reach TLR.
- Strobes are Moore, decoded from the current state:
  - CaptureIR=(CAP_IR); ShiftIR=(SH_IR); UpdateIR=(UPD_IR); same mapping for the DR strobes.
  - The IR captures and shifts on the rising edge ending the state; it updates on the falling edge inside UPD_IR.
- Decode (combinational from IR_PO):
  - OP_IDCODE -> SelIdcode.
  - OP_BIST_STATUS -> SelBistStatus.
  - Every other code, including 8'hFF and OP_BIST_RUN -> SelBypass.
  - Exactly one select is high at all times; TapReset forces SelBypass.
- Bypass register:
  - CaptureDR & SelBypass loads 0.
  - ShiftDR & SelBypass loads TDI.
  - Otherwise holds.
- TDO (combinational):
  - ShiftIR -> IR_SO.
  - ShiftDR -> IDCODE_SO, BIST_SO or the bypass bit, per the active select.
  - Otherwise 0.
  - TDO_EN = ShiftIR | ShiftDR.
- BistStart:
  - High for exactly one cycle when the state enters RTI from UPD_IR or UPD_DR while IR_PO==OP_BIST_RUN.
  - Staying in RTI never re-pulses.
  - Entry from TLR never pulses.
- TMS or TDI X/Z is not handled; the bench must drive both inputs clean.

Decomposition:
- Package tap_pkg:
  - 4-bit state enum with 1149.1 codes: TLR=F, RTI=C, SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PAU_DR=3, EX2_DR=0, UPD_DR=5, SEL_IR=4, CAP_IR=E, SH_IR=A, EX1_IR=9, PAU_IR=B, EX2_IR=8, UPD_IR=D.
  - Opcode constants.
- Sub-module tap_fsm: next-state logic and state register only.
- Decode, bypass register, TDO mux and BistStart stay in tap_ctrl.

Test Plan:
- TRESET=1, then TMS=0 for 1 cycle -> TapReset=1 during reset, TapState=F; after the cycle TapState=C and TapReset=0.
- From RTI apply TMS 1,1,0,0 then 0×8 -> CaptureIR high 1 cycle, ShiftIR high 8 cycles, TDO_EN=1 throughout, TDO equals IR_SO each cycle.
- Shift IR=8'h02, then TMS 1,1,0 -> UpdateIR 1 cycle, then RTI with BistStart=1 for exactly 1 cycle; 10 further TMS=0 cycles give no new pulse.
- IR_PO=8'hFF; DR scan of 4 bits with TDI=1,0,1,1 -> TDO=0,1,0,1 (bypass delays by one cycle); SelBypass=1.
- IR_PO=8'h01 and 8'h03 in turn; DR scan -> TDO follows IDCODE_SO, then BIST_SO; 8'h55 gives SelBypass.
- Park in PAU_DR, apply TMS=1 for 5 cycles -> TapState=F; also TRESET asserted in SH_IR -> TLR next edge with no UpdateIR.
